// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (fetch vs load/store) with an ACK_n watchdog.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin instead of data-over-fetch priority.
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack_n,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_write,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack_n,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic [ADDR_W-1:0] MAD,
   output logic              MREQ,
   output logic              WRITE,
   output logic [1:0]        SIZE,
   output logic [DATA_W-1:0] MDT_o,
   input  logic [DATA_W-1:0] MDT_i,
   input  logic              ACK_n,
   output logic [1:0]        dbg_state
);

   // Encoding is visible on dbg_state: 0 = IDLE, 1 = IBUS, 2 = DBUS.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IBUS = 2'd1,
      DBUS = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t            state, state_nx;
   logic [15:0]       wd_cnt;
   logic              grant_i, grant_d;
   logic              bus_done, timeout;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_fetch;  // 1 = fetch owned the bus last, 0 = data
`endif

   assign dbg_state = state;

   always_comb begin
      state_nx = state;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      timeout  = 1'b0;
      bus_done = 1'b0;
      case (state)
         IDLE: begin
            if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               grant_d = last_fetch;
               grant_i = !last_fetch;
`else
               grant_d = 1'b1;
`endif
            end else begin
               grant_d = d_req;
               grant_i = i_req;
            end
            if (grant_d)      state_nx = DBUS;
            else if (grant_i) state_nx = IBUS;
         end
         IBUS, DBUS: begin
            // A real acknowledge in the same cycle as the timeout wins.
            timeout  = ACK_n && (wd_cnt == TIMEOUT_CNT);
            bus_done = !ACK_n || timeout;
            if (bus_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      i_ack_n = 1'b1;
      d_ack_n = 1'b1;
      i_rdata = i_rdata_q;
      d_rdata = d_rdata_q;
      err     = timeout;
      if (state == IBUS && bus_done) begin
         i_ack_n = 1'b0;
         i_rdata = ACK_n ? '0 : MDT_i;
      end
      if (state == DBUS && bus_done) begin
         d_ack_n = 1'b0;
         d_rdata = ACK_n ? '0 : MDT_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         wd_cnt    <= '0;
         MREQ      <= 1'b0;
         WRITE     <= 1'b0;
         SIZE      <= 2'b00;
         MAD       <= '0;
         MDT_o     <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state <= state_nx;
         if (grant_d || grant_i) begin
            wd_cnt <= '0;
            MREQ   <= 1'b1;
            MAD    <= grant_d ? d_addr : i_addr;
            WRITE  <= grant_d && d_write;
            SIZE   <= grant_d ? d_size : 2'b00;
            MDT_o  <= grant_d ? d_wdata : '0;
         end else if (state != IDLE) begin
            if (bus_done) MREQ   <= 1'b0;
            else          wd_cnt <= wd_cnt + 16'd1;
         end
         if (!i_ack_n) i_rdata_q <= i_rdata;
         if (!d_ack_n) d_rdata_q <= d_rdata;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!rst)                    last_fetch <= 1'b0;
      else if (grant_d || grant_i) last_fetch <= grant_i;
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, random transactions and multi-cycle corner sequences.
// Inputs are driven and registered outputs sampled at negedge; combinational acks are sampled #1 later.
module tb_mem_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req, d_req, d_write, i_ack_n, d_ack_n, err;
   logic [AW-1:0] i_addr, d_addr, MAD;
   logic [DW-1:0] d_wdata, i_rdata, d_rdata, MDT_o, MDT_i;
   logic [1:0]    d_size, SIZE, dbg_state;
   logic          MREQ, WRITE, ACK_n;

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];

   typedef struct {
      bit          is_data;
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      int          lat;
      logic [31:0] rd;
      logic [31:0] e_mad;
      bit          e_wr;
      logic [1:0]  e_sz;
      logic [31:0] e_wd;
   } vec_t;

   vec_t vecs[5];

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack_n(i_ack_n), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack_n(d_ack_n), .d_rdata(d_rdata), .err(err),
      .MAD(MAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .MDT_o(MDT_o),
      .MDT_i(MDT_i), .ACK_n(ACK_n), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
      end
   endtask

   // Waits for the grant, checks bus signals every bus cycle and acks in bus cycle lat.
   task automatic serve(input bit is_data, input int lat, input logic [DW-1:0] rd,
                        input logic [AW-1:0] e_mad, input bit e_wr,
                        input logic [1:0] e_sz, input logic [DW-1:0] e_wd);
      int waited = 0;
      logic [DW-1:0] exp = '0;
      while (MREQ !== 1'b1 && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check("grant_latency", waited, 1);
      if (MREQ !== 1'b1) return;
      for (int c = 1; c <= lat; c++) begin
         if (c > 1) @(negedge clk);
         check("mreq", MREQ, 1'b1);
         check("mad", MAD, e_mad);
         check("write", WRITE, e_wr);
         check("size", SIZE, e_sz);
         if (is_data) check("mdt_o", MDT_o, e_wd);
         if (c == lat) begin
            ACK_n = 1'b0;
            MDT_i = rd;
         end
         #1;
         if (c == lat) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else exp = exp_q.pop_front();
            check("owner_ack", is_data ? d_ack_n : i_ack_n, 1'b0);
            check("owner_rdata", is_data ? d_rdata : i_rdata, exp);
            check("other_ack", is_data ? i_ack_n : d_ack_n, 1'b1);
            check("err_quiet", err, 1'b0);
         end else begin
            check("owner_wait", is_data ? d_ack_n : i_ack_n, 1'b1);
         end
      end
      @(negedge clk);
      ACK_n = 1'b1;
      MDT_i = $urandom;
      check("idle_mreq", MREQ, 1'b0);
      #1;
      check("ack_single", is_data ? d_ack_n : i_ack_n, 1'b1);
      check("rdata_hold", is_data ? d_rdata : i_rdata, exp);
   endtask

   task automatic run_vec(input vec_t v);
      if (v.is_data) begin
         d_req = 1'b1; d_write = v.wr; d_size = v.sz; d_addr = v.addr; d_wdata = v.wd;
         i_addr = $urandom;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
         d_addr = $urandom; d_wdata = $urandom; d_write = 1'b1; d_size = 2'b11;
      end
      exp_q.push_back(v.rd);
      serve(v.is_data, v.lat, v.rd, v.e_mad, v.e_wr, v.e_sz, v.e_wd);
      if (v.is_data) d_req = 1'b0;
      else           i_req = 1'b0;
   endtask

   initial begin
      vec_t r;
      bit   first_data;
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_size = 2'b00;
      i_addr = '0; d_addr = '0; d_wdata = '0; MDT_i = '0; ACK_n = 1'b1;

      vecs[0] = '{0, 0, 2'b00, 32'h0000_0100, 32'h0, 2, 32'h0000_0013, 32'h0000_0100, 0, 2'b00, 32'h0};
      vecs[1] = '{1, 1, 2'b10, 32'hF000_0000, 32'h41, 3, 32'h0BAD_F00D, 32'hF000_0000, 1, 2'b10, 32'h41};
      vecs[2] = '{1, 0, 2'b01, 32'h0000_2000, 32'h5555, 1, 32'h0000_BEEF, 32'h0000_2000, 0, 2'b01, 32'h5555};
      vecs[3] = '{1, 0, 2'b00, 32'h0000_3004, 32'h0, 2, 32'h1234_5678, 32'h0000_3004, 0, 2'b00, 32'h0};
      vecs[4] = '{0, 0, 2'b00, 32'h0000_0104, 32'h0, 1, 32'hCAFE_F00D, 32'h0000_0104, 0, 2'b00, 32'h0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_mreq", MREQ, 1'b0);
      check("rst_write", WRITE, 1'b0);
      check("rst_size", SIZE, 2'b00);
      check("rst_mad", MAD, 0);
      check("rst_mdt_o", MDT_o, 0);
      check("rst_state", dbg_state, 2'd0);
      check("rst_i_ack", i_ack_n, 1'b1);
      check("rst_d_ack", d_ack_n, 1'b1);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_err", err, 1'b0);
      rst = 1'b1;

      // ACK_n low while idle must be ignored
      ACK_n = 1'b0;
      repeat (2) begin
         @(negedge clk);
         #1;
         check("idle_ack_mreq", MREQ, 1'b0);
         check("idle_ack_i", i_ack_n, 1'b1);
         check("idle_ack_d", d_ack_n, 1'b1);
         check("idle_ack_err", err, 1'b0);
      end
      ACK_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 5; k++) run_vec(vecs[k]);

      for (int k = 0; k < 4; k++) begin
         r.is_data = 1'($urandom_range(0, 1));
         r.wr = 1'($urandom_range(0, 1));
         r.sz = 2'($urandom_range(0, 3));
         r.addr = $urandom; r.wd = $urandom; r.rd = $urandom;
         r.lat = $urandom_range(1, 4);
         r.e_mad = r.addr;
         r.e_wr = r.is_data ? r.wr : 1'b0;
         r.e_sz = r.is_data ? r.sz : 2'b00;
         r.e_wd = r.wd;
         run_vec(r);
      end

      // Watchdog: TIMEOUT=4, ack forced on the 5th bus cycle with zero data and err
      d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0000_4000;
      exp_q.push_back('0);
      begin
         int waited = 0;
         while (MREQ !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
         end
         check("to_grant_latency", waited, 1);
      end
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) @(negedge clk);
         #1;
         if (c < 5) begin
            check("to_wait_ack", d_ack_n, 1'b1);
            check("to_wait_err", err, 1'b0);
         end else begin
            check("to_ack", d_ack_n, 1'b0);
            check("to_rdata", d_rdata, exp_q.size() != 0 ? exp_q.pop_front() : 32'hFFFF_FFFF);
            check("to_err", err, 1'b1);
            check("to_i_ack", i_ack_n, 1'b1);
         end
      end
      @(negedge clk);
      check("to_idle_mreq", MREQ, 1'b0);
      check("to_idle_state", dbg_state, 2'd0);
      #1;
      check("to_err_pulse", err, 1'b0);
      d_req = 1'b0;
      @(negedge clk);

      // Reset during DBUS aborts without ack; held request is granted again
      d_req = 1'b1; d_write = 1'b1; d_size = 2'b01; d_addr = 32'h0000_5000; d_wdata = 32'h99;
      @(negedge clk);
      check("rm_mreq_up", MREQ, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rm_mreq", MREQ, 1'b0);
      check("rm_mad", MAD, 0);
      check("rm_state", dbg_state, 2'd0);
      #1;
      check("rm_d_ack", d_ack_n, 1'b1);
      rst = 1'b1;
      exp_q.push_back(32'h77);
      serve(1, 1, 32'h77, 32'h0000_5000, 1, 2'b01, 32'h99);
      d_req = 1'b0;

      // Simultaneous requests after a data grant
`ifdef ARB_ROUND_ROBIN_EN
      first_data = 1'b0;
`else
      first_data = 1'b1;
`endif
      i_req = 1'b1; i_addr = 32'h0000_0200;
      d_req = 1'b1; d_write = 1'b0; d_size = 2'b00; d_addr = 32'h0000_6000; d_wdata = 32'h0;
      if (first_data) begin
         exp_q.push_back(32'hD0D0_D0D0);
         exp_q.push_back(32'h1111_1111);
         serve(1, 1, 32'hD0D0_D0D0, 32'h0000_6000, 0, 2'b00, 32'h0);
         d_req = 1'b0;
         serve(0, 1, 32'h1111_1111, 32'h0000_0200, 0, 2'b00, 32'h0);
         i_req = 1'b0;
      end else begin
         exp_q.push_back(32'h1111_1111);
         exp_q.push_back(32'hD0D0_D0D0);
         serve(0, 1, 32'h1111_1111, 32'h0000_0200, 0, 2'b00, 32'h0);
         i_req = 1'b0;
         serve(1, 1, 32'hD0D0_D0D0, 32'h0000_6000, 0, 2'b00, 32'h0);
         d_req = 1'b0;
      end

      check("sb_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
